// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with an integrated write-pending scoreboard.
// Latency: reads are combinational (0 cycles); writes and busy updates land at the clock edge.
// Backpressure: none; decode stalls on RAW hazards by watching r_busy/busy.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   w_en/w_addr/w_data   NWR packed write ports (port i at [i*W +: W])
//   r_addr/r_data/r_busy NRD packed combinational read ports
//   iss_en/iss_addr      mark the issuing instruction's destination busy
//   flush                clear every busy bit
//   busy                 full scoreboard vector, straight from flops
//
// Optional feature macro: REGFILE_BYPASS_EN enables write-through forwarding
// from same-cycle writes to the read ports (and reports such reads as not busy).
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int NRD    = 4,
  parameter int NWR    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NWR-1:0]          w_en,
  input  logic [NWR*ADDR_W-1:0]   w_addr,
  input  logic [NWR*DATA_W-1:0]   w_data,
  input  logic [NRD*ADDR_W-1:0]   r_addr,
  output logic [NRD*DATA_W-1:0]   r_data,
  output logic [NRD-1:0]          r_busy,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_addr,
  input  logic                    flush,
  output logic [NREGS-1:0]        busy
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy_q;

  logic [DATA_W-1:0] w_reg_d [NREGS];
  logic [NREGS-1:0]  w_wr_hit;
  logic [NREGS-1:0]  w_iss_hit;
  logic [NREGS-1:0]  w_busy_d;

  // Next register contents. Ports are scanned in ascending order so the
  // highest-numbered enabled port targeting an address overwrites the others.
  always_comb begin
    w_wr_hit = '0;
    for (int k = 0; k < NREGS; k++) begin
      w_reg_d[k] = r_regs[k];
    end
    for (int i = 0; i < NWR; i++) begin
      if (w_en[i]) begin
        w_wr_hit[w_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
        w_reg_d[w_addr[i*ADDR_W +: ADDR_W]]  = w_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Scoreboard next state: flush beats everything, then a new issue beats a
  // retiring write to the same register (the new producer supersedes it).
  always_comb begin
    w_iss_hit = '0;
    if (iss_en) begin
      w_iss_hit[iss_addr] = 1'b1;
    end
    if (flush) begin
      w_busy_d = '0;
    end else begin
      w_busy_d = w_iss_hit | (r_busy_q & ~w_wr_hit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
      r_busy_q <= '0;
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= w_reg_d[k];
      end
      r_busy_q <= w_busy_d;
    end
  end

  assign busy = r_busy_q;

  for (genvar gj = 0; gj < NRD; gj++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    assign w_ra = r_addr[gj*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;

    // Forward the winning same-cycle write; gated by rst_n so reads stay
    // zero while reset is held.
    always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
      for (int i = 0; i < NWR; i++) begin
        if (rst_n && w_en[i] && (w_addr[i*ADDR_W +: ADDR_W] == w_ra)) begin
          w_fwd_hit  = 1'b1;
          w_fwd_data = w_data[i*DATA_W +: DATA_W];
        end
      end
    end

    assign r_data[gj*DATA_W +: DATA_W] = w_fwd_hit ? w_fwd_data : r_regs[w_ra];
    assign r_busy[gj]                  = !w_fwd_hit && r_busy_q[w_ra];
`else
    assign r_data[gj*DATA_W +: DATA_W] = r_regs[w_ra];
    assign r_busy[gj]                  = r_busy_q[w_ra];
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 4;
  localparam int RD = 4;
  localparam int WR = 3;

  logic              clk;
  logic              rst_n;
  logic [WR-1:0]     w_en;
  logic [WR*AW-1:0]  w_addr;
  logic [WR*DW-1:0]  w_data;
  logic [RD*AW-1:0]  r_addr;
  logic [RD*DW-1:0]  r_data;
  logic [RD-1:0]     r_busy;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              flush;
  logic [NR-1:0]     busy;

  regfile_sb #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .NRD(RD), .NWR(WR)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_addr(r_addr), .r_data(r_data), .r_busy(r_busy),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: plain arrays holding what the architecture says.
  logic [DW-1:0] mdl_reg  [NR];
  bit            mdl_busy [NR];

  task automatic mdl_clear();
    for (int k = 0; k < NR; k++) begin
      mdl_reg[k]  = '0;
      mdl_busy[k] = 1'b0;
    end
  endtask

  initial mdl_clear();

  always @(negedge rst_n) mdl_clear();

  always @(posedge clk) begin
    if (!rst_n) begin
      mdl_clear();
    end else begin
      // Writes applied one port at a time, last port applied last, so it wins.
      for (int i = 0; i < WR; i++)
        if (w_en[i]) mdl_reg[w_addr[i*AW +: AW]] = w_data[i*DW +: DW];
      if (flush) begin
        for (int k = 0; k < NR; k++) mdl_busy[k] = 1'b0;
      end else begin
        for (int i = 0; i < WR; i++)
          if (w_en[i]) mdl_busy[w_addr[i*AW +: AW]] = 1'b0;
        if (iss_en) mdl_busy[iss_addr] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected combinational read for port j from model state plus current inputs.
  task automatic exp_rd(input int j, output logic [DW-1:0] d, output logic b);
    logic [AW-1:0] a;
    a = r_addr[j*AW +: AW];
    d = mdl_reg[a];
    b = mdl_busy[a];
`ifdef REGFILE_BYPASS_EN
    if (rst_n) begin
      for (int i = 0; i < WR; i++) begin
        if (w_en[i] && w_addr[i*AW +: AW] == a) begin
          d = w_data[i*DW +: DW];
          b = 1'b0;
        end
      end
    end
`endif
  endtask

  // Single compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    logic [DW-1:0] ed;
    logic          eb;
    logic [NR-1:0] ev;
    #1;
    if (chk_en) begin
      for (int j = 0; j < RD; j++) begin
        exp_rd(j, ed, eb);
        chk($sformatf("rd_data[%0d]", j), r_data[j*DW +: DW], ed);
        chk($sformatf("rd_busy[%0d]", j), {31'd0, r_busy[j]}, {31'd0, eb});
      end
      for (int k = 0; k < NR; k++) ev[k] = mdl_busy[k];
      chk("busy_vec", {16'd0, busy}, {16'd0, ev});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    w_en = '0; w_addr = '0; w_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    w_en[i] = 1'b1;
    w_addr[i*AW +: AW] = a;
    w_data[i*DW +: DW] = d;
  endtask

  task automatic set_rd(input int j, input logic [AW-1:0] a);
    r_addr[j*AW +: AW] = a;
  endtask

  initial begin
    rst_n = 1'b0;
    r_addr = '0;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    #2;
    chk("reset_busy", {16'd0, busy}, 32'h0);
    chk("reset_rdata0", r_data[0 +: DW], 32'h0);

    // Collision: all three ports to reg 5, highest port wins.
    tick();
    set_wr(0, 4'd5, 32'hA); set_wr(1, 4'd5, 32'hB); set_wr(2, 4'd5, 32'hC);
    tick();
    idle();
    set_rd(0, 4'd5);
    #2;
    chk("collide_all_5", r_data[0 +: DW], 32'hC);

    // Collision on 5 via ports 0 and 2 while port 1 writes reg 6.
    tick();
    set_wr(0, 4'd5, 32'h11); set_wr(1, 4'd6, 32'h66); set_wr(2, 4'd5, 32'h22);
    tick();
    idle();
    set_rd(0, 4'd5); set_rd(1, 4'd6);
    #2;
    chk("collide_5_again", r_data[0 +: DW], 32'h22);
    chk("side_write_6", r_data[DW +: DW], 32'h66);

    // Scoreboard lifecycle on reg 3.
    tick();
    iss_en = 1'b1; iss_addr = 4'd3;
    tick();
    idle();
    set_rd(2, 4'd3);
    #2;
    chk("busy3_set", {31'd0, busy[3]}, 32'd1);
    chk("rbusy_port2_set", {31'd0, r_busy[2]}, 32'd1);
    tick();
    set_wr(0, 4'd3, 32'h1234);
    tick();
    idle();
    #2;
    chk("busy3_clr", {31'd0, busy[3]}, 32'd0);
    chk("rdata3", r_data[2*DW +: DW], 32'h1234);

    // Issue and write of reg 7 in the same cycle: set wins, data lands.
    tick();
    iss_en = 1'b1; iss_addr = 4'd7; set_wr(0, 4'd7, 32'h77);
    tick();
    idle();
    set_rd(3, 4'd7);
    #2;
    chk("busy7_setwins", {31'd0, busy[7]}, 32'd1);
    chk("rdata7", r_data[3*DW +: DW], 32'h77);

    // Build busy = 0x00F0, then flush alongside an issue to reg 2.
    for (int k = 4; k < 7; k++) begin
      tick();
      idle();
      iss_en = 1'b1; iss_addr = AW'(k);
    end
    tick();
    idle();
    #2;
    chk("busy_f0", {16'd0, busy}, 32'h00F0);
    tick();
    flush = 1'b1; iss_en = 1'b1; iss_addr = 4'd2;
    tick();
    idle();
    #2;
    chk("flush_clears", {16'd0, busy}, 32'h0);

    // Same-cycle read of a register being written while busy.
    tick();
    iss_en = 1'b1; iss_addr = 4'd4;
    tick();
    idle();
    set_wr(1, 4'd4, 32'hDEAD);
    set_rd(0, 4'd4);
    #2;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_data", r_data[0 +: DW], 32'hDEAD);
    chk("bypass_busy", {31'd0, r_busy[0]}, 32'd0);
`else
    chk("nobypass_data", r_data[0 +: DW], 32'h0);
    chk("nobypass_busy", {31'd0, r_busy[0]}, 32'd1);
`endif
    tick();
    idle();
    #2;
    chk("after_write4", r_data[0 +: DW], 32'hDEAD);
    chk("busy4_clr", {31'd0, busy[4]}, 32'd0);

    // Pseudo-random traffic, checked by the model only.
    for (int n = 0; n < 60; n++) begin
      tick();
      idle();
      for (int i = 0; i < WR; i++)
        if ($urandom_range(0, 1) == 1) set_wr(i, AW'($urandom_range(0, NR-1)), $urandom);
      iss_en = ($urandom_range(0, 2) == 0);
      iss_addr = AW'($urandom_range(0, NR-1));
      flush = ($urandom_range(0, 15) == 0);
      for (int j = 0; j < RD; j++) set_rd(j, AW'($urandom_range(0, NR-1)));
    end

    // Make sure state is non-trivial, then assert reset mid-cycle.
    tick();
    idle();
    set_wr(0, 4'd9, 32'hCAFE); iss_en = 1'b1; iss_addr = 4'd9;
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", {16'd0, busy}, 32'h0);
    for (int g = 0; g < NR / RD; g++) begin
      for (int j = 0; j < RD; j++) set_rd(j, AW'(g * RD + j));
      #1;
      for (int j = 0; j < RD; j++)
        chk($sformatf("midreset_reg%0d", g * RD + j), r_data[j*DW +: DW], 32'h0);
    end
    tick();
    rst_n = 1'b1;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
